jtcop_obj_dma: RTL and testbench



---
 rtl/jtcop_pkg.sv | 13 +
 rtl/jtcop_obj_dma.sv | 113 +++++++++++
 tb/tb_jtcop_obj_dma.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jtcop_pkg.sv
// rtl/jtcop_pkg.sv - shared constants and state encoding for the CPS object path
package jtcop_pkg;

  localparam int OBJ_AW = 10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    COPY,
    FIN
  } dma_state_t;

endpackage

// File: rtl/jtcop_obj_dma.sv
// rtl/jtcop_obj_dma.sv - copies CPU object RAM into the renderer shadow buffer
module jtcop_obj_dma
  import jtcop_pkg::*;
#(
  parameter int AW    = OBJ_AW,
  parameter bit DEFER = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          LVBL,
  input  logic          obj_copy,
  input  logic          mixpsel,
  output logic [AW-1:0] src_addr,
  input  logic [15:0]   src_dout,
  output logic [AW:0]   buf_addr,
  output logic [15:0]   buf_din,
  output logic          buf_we,
  output logic          busy,
  output logic          done
);

  localparam logic [AW:0] CNT_END = {1'b1, {AW{1'b0}}};

  dma_state_t  st;
  logic        lvbl_l;
  logic        vb_start;
  logic        go_now;
  logic        rearm;
  logic        load;
  logic        pending;
  logic        bank;
  logic        rd_v;
  logic [AW:0] cnt;

  assign vb_start = lvbl_l & ~LVBL;
  assign go_now   = ~DEFER | ~LVBL;
  assign rearm    = pending | obj_copy;
  // RAM data arrives one clk after src_addr, which lines up with the write stage
  assign buf_din  = buf_we ? src_dout : 16'd0;

  always_comb begin
    load = 1'b0;
    case (st)
      IDLE:    load = obj_copy & go_now;
      WAIT:    load = vb_start;
      FIN:     load = rearm & go_now;
      default: load = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      lvbl_l   <= 1'b1;
      pending  <= 1'b0;
      bank     <= 1'b0;
      rd_v     <= 1'b0;
      cnt      <= '0;
      src_addr <= '0;
      buf_addr <= '0;
      buf_we   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      lvbl_l <= LVBL;
      done   <= 1'b0;
      buf_we <= 1'b0;
      case (st)
        IDLE: begin
          if (obj_copy) begin
            busy <= 1'b1;
            st   <= WAIT;
          end
        end
        WAIT: begin
        end
        COPY: begin
          if (obj_copy) pending <= 1'b1;
          buf_we   <= rd_v;
          buf_addr <= {bank, src_addr};
          // cnt holds the next word to issue; once it hits 2^AW only the drain write remains
          if (!rd_v) begin
            st   <= FIN;
            done <= 1'b1;
          end else if (cnt == CNT_END) begin
            rd_v <= 1'b0;
          end else begin
            src_addr <= cnt[AW-1:0];
            cnt      <= cnt + 1'b1;
          end
        end
        FIN: begin
          pending <= 1'b0;
          if (rearm) begin
            st <= WAIT;
          end else begin
            st   <= IDLE;
            busy <= 1'b0;
          end
        end
        default: st <= IDLE;
      endcase
      if (load) begin
        st       <= COPY;
        bank     <= mixpsel;
        cnt      <= {{AW{1'b0}}, 1'b1};
        src_addr <= '0;
        rd_v     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jtcop_obj_dma.sv
// tb/tb_jtcop_obj_dma.sv - directed bench for the object DMA engine
module tb_jtcop_obj_dma;
  import jtcop_pkg::*;

  localparam int AW    = OBJ_AW;
  localparam int WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          LVBL = 1'b1;
  logic          obj_copy = 1'b0;
  logic          mixpsel = 1'b0;
  logic [AW-1:0] src_addr;
  logic [15:0]   src_dout = 16'd0;
  logic [AW:0]   buf_addr;
  logic [15:0]   buf_din;
  logic          buf_we;
  logic          busy;
  logic          done;

  int total = 0;
  int bad = 0;

  logic [15:0] src_mem [0:WORDS-1];
  logic [15:0] shadow  [0:2*WORDS-1];
  int          wr_cnt  [0:2*WORDS-1];
  int          writes = 0;
  int          done_cnt = 0;

  jtcop_obj_dma #(.AW(AW), .DEFER(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .LVBL     (LVBL),
    .obj_copy (obj_copy),
    .mixpsel  (mixpsel),
    .src_addr (src_addr),
    .src_dout (src_dout),
    .buf_addr (buf_addr),
    .buf_din  (buf_din),
    .buf_we   (buf_we),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) src_dout <= src_mem[src_addr];

  always @(posedge clk) begin
    if (buf_we) begin
      shadow[buf_addr] <= buf_din;
      wr_cnt[buf_addr] = wr_cnt[buf_addr] + 1;
      writes = writes + 1;
    end
    if (done) done_cnt = done_cnt + 1;
  end

  function automatic logic [15:0] pat(input int mode, input int a);
    logic [15:0] av;
    av = a[15:0];
    if (mode == 0) return ~av;
    return av * 16'd3 + 16'h1234;
  endfunction

  task automatic fill_src(input int mode);
    for (int i = 0; i < WORDS; i++) src_mem[i] = pat(mode, i);
  endtask

  task automatic clear_log();
    for (int i = 0; i < 2*WORDS; i++) begin
      wr_cnt[i] = 0;
      shadow[i] = 16'd0;
    end
    writes = 0;
    done_cnt = 0;
  endtask

  function automatic int count_bank(input int b, input int expect_n);
    int n;
    n = 0;
    for (int i = 0; i < WORDS; i++) if (wr_cnt[b*WORDS + i] != expect_n) n++;
    return n;
  endfunction

  function automatic int check_data(input int b, input int mode);
    int n;
    n = 0;
    for (int i = 0; i < WORDS; i++) if (shadow[b*WORDS + i] !== pat(mode, i)) n++;
    return n;
  endfunction

  task automatic pulse_copy();
    @(negedge clk) obj_copy = 1'b1;
    @(negedge clk) obj_copy = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    while (cycles < budget && !ok) begin
      @(negedge clk);
      cycles++;
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++; if (src_addr !== '0) begin bad++; $display("FAIL rst_src_addr: got %0h want 0", src_addr); end
    total++; if (buf_addr !== '0) begin bad++; $display("FAIL rst_buf_addr: got %0h want 0", buf_addr); end
    total++; if (buf_din !== 16'd0) begin bad++; $display("FAIL rst_buf_din: got %0h want 0", buf_din); end
    total++; if (buf_we !== 1'b0) begin bad++; $display("FAIL rst_buf_we: got %b want 0", buf_we); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0 || buf_we !== 1'b0) begin bad++; $display("FAIL rst_idle: got busy=%b we=%b want 0 0", busy, buf_we); end
  endtask

  task automatic test_deferred();
    int  k;
    clear_log();
    fill_src(0);
    LVBL = 1'b1;
    mixpsel = 1'b0;
    pulse_copy();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL defer_busy: got %b want 1", busy); end
    repeat (20) @(negedge clk);
    total++; if (writes !== 0) begin bad++; $display("FAIL defer_no_write: got %0d writes want 0", writes); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL defer_busy_hold: got %b want 1", busy); end
    LVBL = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 1200) begin
      @(negedge clk);
      k++;
      if (k == 100) LVBL = 1'b1;
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL defer_timeout: got no done after %0d clks want done", k); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL defer_done_width: got %b want 0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL defer_busy_drop: got %b want 0", busy); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL defer_done_cnt: got %0d want 1", done_cnt); end
    total++; if (writes !== WORDS) begin bad++; $display("FAIL defer_writes: got %0d want %0d", writes, WORDS); end
    total++; if (count_bank(0, 1) !== 0) begin bad++; $display("FAIL defer_bank0_once: got %0d bad words want 0", count_bank(0, 1)); end
    total++; if (check_data(0, 0) !== 0) begin bad++; $display("FAIL defer_data: got %0d bad words want 0", check_data(0, 0)); end
  endtask

  task automatic test_latency_bank();
    int k;
    logic [AW:0] exp_addr;
    clear_log();
    LVBL = 1'b0;
    mixpsel = 1'b1;
    repeat (2) @(negedge clk);
    pulse_copy();
    total++; if (src_addr !== '0) begin bad++; $display("FAIL lat_src_addr: got %0h want 0", src_addr); end
    total++; if (buf_we !== 1'b0) begin bad++; $display("FAIL lat_we_early: got %b want 0", buf_we); end
    @(negedge clk);
    exp_addr = {1'b1, {AW{1'b0}}};
    total++; if (buf_we !== 1'b1) begin bad++; $display("FAIL lat_first_we: got %b want 1", buf_we); end
    total++; if (buf_addr !== exp_addr) begin bad++; $display("FAIL lat_first_addr: got %0h want %0h", buf_addr, exp_addr); end
    total++; if (buf_din !== 16'hFFFF) begin bad++; $display("FAIL lat_first_din: got %0h want ffff", buf_din); end
    k = 2;
    while (done !== 1'b1 && k < 1200) begin
      @(negedge clk);
      k++;
      if (k % 100 == 0) mixpsel = ~mixpsel;
    end
    total++; if (k !== 1026) begin bad++; $display("FAIL lat_done_clk: got %0d want 1026", k); end
    @(negedge clk);
    total++; if (count_bank(1, 1) !== 0) begin bad++; $display("FAIL bank_latched: got %0d bad bank1 words want 0", count_bank(1, 1)); end
    total++; if (count_bank(0, 0) !== 0) begin bad++; $display("FAIL bank_other: got %0d bank0 writes want 0", count_bank(0, 0)); end
    total++; if (writes !== WORDS) begin bad++; $display("FAIL bank_writes: got %0d want %0d", writes, WORDS); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    clear_log();
    LVBL = 1'b0;
    mixpsel = 1'b0;
    pulse_copy();
    cyc = 0;
    while (!(done_cnt == 2 && busy === 1'b0) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      obj_copy = (cyc == 50 || cyc == 300 || cyc == 700);
    end
    obj_copy = 1'b0;
    total++; if (cyc >= 3000) begin bad++; $display("FAIL b2b_timeout: got %0d clks want < 3000", cyc); end
    total++; if (done_cnt !== 2) begin bad++; $display("FAIL b2b_done_cnt: got %0d want 2", done_cnt); end
    total++; if (writes !== 2*WORDS) begin bad++; $display("FAIL b2b_writes: got %0d want %0d", writes, 2*WORDS); end
    total++; if (count_bank(0, 2) !== 0) begin bad++; $display("FAIL b2b_twice: got %0d bad words want 0", count_bank(0, 2)); end
    total++; if (count_bank(1, 0) !== 0) begin bad++; $display("FAIL b2b_bank1: got %0d stray words want 0", count_bank(1, 0)); end
  endtask

  task automatic test_reset_mid();
    int  k;
    int  cycles;
    bit  ok;
    clear_log();
    fill_src(1);
    LVBL = 1'b0;
    mixpsel = 1'b0;
    pulse_copy();
    k = 0;
    while (writes < 500 && k < 1200) begin
      @(negedge clk);
      k++;
    end
    total++; if (writes !== 500) begin bad++; $display("FAIL mid_reach500: got %0d writes want 500", writes); end
    rst_n = 1'b0;
    #1;
    total++; if (buf_we !== 1'b0) begin bad++; $display("FAIL mid_rst_we: got %b want 0", buf_we); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    total++; if (src_addr !== '0) begin bad++; $display("FAIL mid_rst_src: got %0h want 0", src_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    repeat (30) @(negedge clk);
    total++; if (writes !== 0) begin bad++; $display("FAIL mid_quiet: got %0d writes want 0", writes); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_quiet_busy: got %b want 0", busy); end
    mixpsel = 1'b1;
    pulse_copy();
    wait_done(1200, cycles, ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_recopy_timeout: got no done in %0d clks want done", cycles); end
    @(negedge clk);
    total++; if (writes !== WORDS) begin bad++; $display("FAIL mid_recopy_writes: got %0d want %0d", writes, WORDS); end
    total++; if (check_data(1, 1) !== 0) begin bad++; $display("FAIL mid_recopy_data: got %0d bad words want 0", check_data(1, 1)); end
    total++; if (count_bank(1, 1) !== 0) begin bad++; $display("FAIL mid_recopy_once: got %0d bad words want 0", count_bank(1, 1)); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_recopy_busy: got %b want 0", busy); end
  endtask

  initial begin
    fill_src(0);
    clear_log();
    test_reset();
    test_deferred();
    test_latency_bank();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
